// File: rtl/mem_dump_pkg.sv
// Shared constants and FSM state type for the mem_dump block.
// Optional checksum beat is enabled by defining MEM_DUMP_CHKSUM_EN.
package mem_dump_pkg;

  localparam int DEPTH  = 1024;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);

  // CSUM exists only when the checksum beat is built in.
`ifdef MEM_DUMP_CHKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WT   = 3'd2,
    ST_SEND = 3'd3,
    ST_CSUM = 3'd4,
    ST_FIN  = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WT   = 3'd2,
    ST_SEND = 3'd3,
    ST_FIN  = 3'd5
  } state_e;
`endif

endpackage

// File: rtl/mem_dump_if.sv
// Bus bundle for mem_dump: command (start/base/count), memory read port,
// output stream and status.
//
// Stream handshake: a beat transfers on every rising clk edge where
// out_valid && out_ready; once out_valid is high, out_data and out_last hold
// steady until that edge, and out_valid never drops without a transfer.
interface mem_dump_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 10
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_rdata;
  logic [WIDTH-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              done;

  // The dump engine side.
  modport master (
    input  start, base_addr, count, mem_rdata, out_ready,
    output mem_addr, out_data, out_valid, out_last, busy, done
  );

  // The environment side: requester, memory image and stream consumer.
  modport slave (
    output start, base_addr, count, mem_rdata, out_ready,
    input  mem_addr, out_data, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/mem_dump.sv
// mem_dump: streams count words of an external memory image starting at
// base_addr, one word per three cycles (RD -> WT -> SEND). Addresses wrap
// modulo DEPTH. Define MEM_DUMP_CHKSUM_EN to append a WIDTH-bit sum of the
// emitted words as a final beat.
module mem_dump
  import mem_dump_pkg::*;
#(
  parameter int DEPTH = mem_dump_pkg::DEPTH,
  parameter int WIDTH = mem_dump_pkg::WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  mem_dump_if.master        bus,
  output mem_dump_pkg::state_e state_o
);

  localparam int AW = $clog2(DEPTH);

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [AW:0]     remain_q, remain_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            hs;
  logic [AW-1:0]   ptr_inc;
`ifdef MEM_DUMP_CHKSUM_EN
  logic [WIDTH-1:0] csum_q, csum_d;
`endif

  assign hs      = valid_q && bus.out_ready;
  assign ptr_inc = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;

  // The pointer register doubles as the memory read address.
  assign bus.mem_addr  = ptr_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign bus.done      = (state_q == ST_FIN);
  assign state_o       = state_q;

  // Next-state and datapath decode.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    remain_d = remain_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
`ifdef MEM_DUMP_CHKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          ptr_d    = bus.base_addr;
          remain_d = bus.count;
`ifdef MEM_DUMP_CHKSUM_EN
          csum_d   = '0;
`endif
          if (bus.count != '0) begin
            state_d = ST_RD;
          end else begin
`ifdef MEM_DUMP_CHKSUM_EN
            // Empty dump still emits the (zero) checksum beat.
            data_d  = '0;
            valid_d = 1'b1;
            last_d  = 1'b1;
            state_d = ST_CSUM;
`else
            state_d = ST_FIN;
`endif
          end
        end
      end
      ST_RD: begin
        state_d = ST_WT;
      end
      ST_WT: begin
        data_d  = bus.mem_rdata;
        valid_d = 1'b1;
`ifdef MEM_DUMP_CHKSUM_EN
        last_d  = 1'b0;
`else
        last_d  = (remain_q == (AW + 1)'(1));
`endif
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (hs) begin
          valid_d  = 1'b0;
          last_d   = 1'b0;
          ptr_d    = ptr_inc;
          remain_d = remain_q - 1'b1;
`ifdef MEM_DUMP_CHKSUM_EN
          csum_d   = csum_q + data_q;
`endif
          if (remain_q != (AW + 1)'(1)) begin
            state_d = ST_RD;
          end else begin
`ifdef MEM_DUMP_CHKSUM_EN
            data_d  = csum_q + data_q;
            valid_d = 1'b1;
            last_d  = 1'b1;
            state_d = ST_CSUM;
`else
            state_d = ST_FIN;
`endif
          end
        end
      end
`ifdef MEM_DUMP_CHKSUM_EN
      ST_CSUM: begin
        if (hs) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = ST_FIN;
        end
      end
`endif
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any dump in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      remain_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
`ifdef MEM_DUMP_CHKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      remain_q <= remain_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
`ifdef MEM_DUMP_CHKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_dump.sv
// Testbench for mem_dump: directed table of dumps over an identity memory
// image, hand-written stall/reset/restart sequences, then random dumps over a
// random image, all compared against a queue-based reference of the stream.
module tb_mem_dump;
  import mem_dump_pkg::*;

`ifdef MEM_DUMP_CHKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int LIMIT = 5000;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_e dbg_state;

  mem_dump_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  mem_dump #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // ---------------- clock / reset / memory image ----------------
  always #5 clk = ~clk;

  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [WIDTH:0] got_q[$];   // {last, data}
  logic [WIDTH:0] exp_q[$];
  int done_cnt = 0;
  bit prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: record beats, done pulses, and hold-while-stalled behaviour.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && bus.out_valid)
        check("stall_hold", 32'(bus.out_data), 32'(prev_data));
      if (bus.out_valid && bus.out_ready)
        got_q.push_back({bus.out_last, bus.out_data});
      if (bus.done) begin
        done_cnt++;
        check("busy_low_with_done", 32'(bus.busy), 32'd0);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  // Reference: the stream is count consecutive words (addresses mod DEPTH),
  // last flag on the final data word, or on an appended sum when enabled.
  task automatic build_exp(input int base, input int cnt);
    logic [WIDTH-1:0] sum;
    sum = '0;
    exp_q.delete();
    for (int i = 0; i < cnt; i++) begin
      logic [WIDTH-1:0] w;
      w = mem[(base + i) % DEPTH];
      sum += w;
      exp_q.push_back({(i == cnt - 1) && !CHK, w});
    end
    if (CHK) exp_q.push_back({1'b1, sum});
  endtask

  // ---------------- driver ----------------
  // Called and returns at posedge+1. mode: 0 ready=1, 1 random ready,
  // 2 hold ready low for 5 cycles while beat index 2 is presented.
  task automatic run_dump(input int base, input int cnt, input int mode,
                          input bit restart, output int first, output int stalls);
    int cyc;
    got_q.delete();
    done_cnt = 0;
    first = -1;
    stalls = 0;
    cyc = 0;
    bus.out_ready = 1'b1;
    bus.base_addr = ADDR_W'(base);
    bus.count     = (ADDR_W + 1)'(cnt);
    bus.start     = 1'b1;
    while (done_cnt == 0 && cyc < LIMIT) begin
      @(posedge clk); #1;
      cyc++;
      bus.start = 1'b0;
      if (restart && cyc == 10) begin
        bus.base_addr = '0;
        bus.count     = (ADDR_W + 1)'(3);
        bus.start     = 1'b1;
      end
      if (first < 0 && bus.out_valid) first = cyc;
      case (mode)
        1: bus.out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (bus.out_valid && got_q.size() == 2 && stalls < 5) begin
            bus.out_ready = 1'b0;
            stalls++;
            check("stall_beat2_data", 32'(bus.out_data), 32'(mem[(base + 2) % DEPTH]));
          end else begin
            bus.out_ready = 1'b1;
          end
        end
        default: bus.out_ready = 1'b1;
      endcase
    end
    if (done_cnt == 0) check("dump_timeout", 32'(cyc), 32'(LIMIT + 1));
    bus.out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic check_stream(input string tag, input int base, input int cnt);
    build_exp(base, cnt);
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    check({tag, "_beats"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int   base;
    int   cnt;
    int   mode;
    bit   restart;
    int   exp_nbeats;     // data beats only
    logic [WIDTH-1:0] exp_first;
    logic [WIDTH-1:0] exp_lastw;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v, input int idx);
    int first, stalls, nd;
    string tag;
    tag = $sformatf("vec%0d", idx);
    run_dump(v.base, v.cnt, v.mode, v.restart, first, stalls);
    nd = got_q.size() - (CHK ? 1 : 0);
    check({tag, "_data_beats"}, 32'(nd), 32'(v.exp_nbeats));
    if (v.exp_nbeats > 0 && nd == v.exp_nbeats) begin
      check({tag, "_first_word"}, 32'(got_q[0][WIDTH-1:0]), 32'(v.exp_first));
      check({tag, "_last_word"}, 32'(got_q[nd-1][WIDTH-1:0]), 32'(v.exp_lastw));
      check({tag, "_latency"}, 32'(first), 32'd3);
    end
    if (v.mode == 2) check({tag, "_stall_cycles"}, 32'(stalls), 32'd5);
    check_stream(tag, v.base, v.cnt);
  endtask

  initial begin
    int first, stalls, cyc;

    vecs[0] = '{0,    4,    0, 1'b0, 4,    16'd0,    16'd3};
    vecs[1] = '{1022, 4,    0, 1'b0, 4,    16'd1022, 16'd1};
    vecs[2] = '{0,    4,    2, 1'b0, 4,    16'd0,    16'd3};
    vecs[3] = '{100,  1,    1, 1'b0, 1,    16'd100,  16'd100};
    vecs[4] = '{1023, 2,    1, 1'b0, 2,    16'd1023, 16'd0};
    vecs[5] = '{200,  0,    0, 1'b0, 0,    16'd0,    16'd0};
    vecs[6] = '{5,    1024, 0, 1'b1, 1024, 16'd5,    16'd4};
    vecs[7] = '{300,  9,    1, 1'b0, 9,    16'd300,  16'd308};

    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i);
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.count = '0;
    bus.out_ready = 1'b1;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset in the middle of an 8-word dump.
    got_q.delete();
    done_cnt = 0;
    bus.base_addr = '0;
    bus.count = (ADDR_W + 1)'(8);
    bus.start = 1'b1;
    cyc = 0;
    while (got_q.size() < 2 && cyc < 100) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      cyc++;
    end
    check("midrst_two_beats", 32'(got_q.size()), 32'd2);
    check("midrst_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    check("midrst_no_more_beats", 32'(got_q.size()), 32'd2);
    run_vec(vecs[0], 100);

    // Random image, random dumps, random back-pressure.
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
    for (int r = 0; r < 15; r++) begin
      int b, c;
      b = $urandom_range(0, DEPTH - 1);
      c = (r == 0) ? 0 : $urandom_range(1, 40);
      run_dump(b, c, 1, 1'b0, first, stalls);
      check_stream($sformatf("rnd%0d", r), b, c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
